// File: rtl/shifter_unit.sv
// Iterative ARM barrel shifter: zero/saturating amounts resolve in one cycle, others shift one bit per cycle.
// Latency 1 cycle (fast path) or count+1 cycles (iterative); a start is ignored while busy.
module shifter_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  shift_type,
    input  logic [31:0] value,
    input  logic [31:0] amount,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        busy,
    output logic        done
);
    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [1:0]  op;
    logic [7:0]  n;
    logic        fast;
    logic [31:0] fast_result;
    logic        fast_carry;

    // Architecturally only the low byte of a register shift amount matters.
    logic unused_amount;
    assign unused_amount = ^amount[31:8];
    assign n = amount[7:0];

    always_comb begin
        fast        = 1'b0;
        fast_result = value;
        fast_carry  = carry_in;
        if (n == 8'd0) begin
            fast = 1'b1;
        end else begin
            case (shift_type)
                LSL: if (n >= 8'd32) begin
                    fast        = 1'b1;
                    fast_result = 32'd0;
                    fast_carry  = (n == 8'd32) ? value[0] : 1'b0;
                end
                LSR: if (n >= 8'd32) begin
                    fast        = 1'b1;
                    fast_result = 32'd0;
                    fast_carry  = (n == 8'd32) ? value[31] : 1'b0;
                end
                ASR: if (n >= 8'd32) begin
                    fast        = 1'b1;
                    fast_result = {32{value[31]}};
                    fast_carry  = value[31];
                end
                default: if (n[4:0] == 5'd0) begin
                    fast        = 1'b1;
                    fast_result = value;
                    fast_carry  = value[31];
                end
            endcase
        end
    end

    // result doubles as the working register while iterating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            result    <= 32'd0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= 5'd0;
            op        <= LSL;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (fast) begin
                            result    <= fast_result;
                            carry_out <= fast_carry;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            result    <= value;
                            carry_out <= carry_in;
                            count     <= n[4:0];
                            op        <= shift_type;
                            busy      <= 1'b1;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    case (op)
                        LSL: begin
                            result    <= {result[30:0], 1'b0};
                            carry_out <= result[31];
                        end
                        LSR: begin
                            result    <= {1'b0, result[31:1]};
                            carry_out <= result[0];
                        end
                        ASR: begin
                            result    <= {result[31], result[31:1]};
                            carry_out <= result[0];
                        end
                        default: begin
                            result    <= {result[0], result[31:1]};
                            carry_out <= result[0];
                        end
                    endcase
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shifter_unit.sv
// Scoreboard bench for shifter_unit: a reference model pushes expected result/carry/done-cycle, a monitor pops on done.
module tb_shifter_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  shift_type;
    logic [31:0] value;
    logic [31:0] amount;
    logic        carry_in;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;
    logic        done;

    shifter_unit dut (
        .clk(clk), .reset(reset), .start(start), .shift_type(shift_type),
        .value(value), .amount(amount), .carry_in(carry_in),
        .result(result), .carry_out(carry_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          due;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // ARM shifter semantics by wide arithmetic; due holds the cycles after the start edge.
    function automatic exp_t model(input logic [1:0] t, input logic [31:0] v,
                                   input logic [31:0] a, input logic c);
        exp_t        e;
        logic [7:0]  n;
        logic [4:0]  m;
        logic [63:0] x;
        n     = a[7:0];
        e.res = v;
        e.c   = c;
        e.due = 0;
        if (n != 8'd0) begin
            case (t)
                2'b00: begin
                    x = {32'd0, v} << n;
                    e.res = x[31:0];
                    e.c   = x[32];
                    e.due = (n < 8'd32) ? int'(n) : 0;
                end
                2'b01: begin
                    x = {v, 32'd0} >> n;
                    e.res = x[63:32];
                    e.c   = x[31];
                    e.due = (n < 8'd32) ? int'(n) : 0;
                end
                2'b10: begin
                    x = $signed({v, 32'd0}) >>> n;
                    e.res = x[63:32];
                    e.c   = x[31];
                    e.due = (n < 8'd32) ? int'(n) : 0;
                end
                default: begin
                    m = n[4:0];
                    e.res = (m == 5'd0) ? v : ((v >> m) | (v << (6'd32 - {1'b0, m})));
                    e.c   = e.res[31];
                    e.due = int'(m);
                end
            endcase
        end
        return e;
    endfunction

    // Called at a negedge; drives one start pulse and scrambles inputs after the sampling edge.
    task automatic poke(input logic [1:0] t, input logic [31:0] v, input logic [31:0] a,
                        input logic c, input bit acc);
        exp_t e;
        shift_type = t;
        value      = v;
        amount     = a;
        carry_in   = c;
        start      = 1'b1;
        if (acc) begin
            e = model(t, v, a, c);
            e.due = e.due + cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        shift_type = 2'($urandom);
        value      = $urandom;
        amount     = $urandom;
        carry_in   = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] v, input logic [31:0] a, input logic c);
        int w;
        w = 0;
        while (busy && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (busy) fail_now("busy_timeout");
        else poke(t, v, a, c, 1'b1);
    endtask

    initial begin
        exp_t e;
        int   w;
        reset = 1'b1;
        start = 1'b0;
        shift_type = 2'b00;
        value = 32'd0;
        amount = 32'd0;
        carry_in = 1'b0;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_carry", {31'd0, carry_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        fork
            forever @(posedge clk) cyc++;
            forever begin
                @(negedge clk);
                if (!reset && done) begin
                    check("busy_with_done", {31'd0, busy}, 32'd0);
                    if (q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = q.pop_front();
                        check("result", result, e.res);
                        check("carry", {31'd0, carry_out}, {31'd0, e.c});
                        check("done_cycle", 32'(cyc), 32'(e.due));
                    end
                end
            end
        join_none

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(2'b00, 32'h8000_0001, 32'd1,          1'b0);
        send(2'b10, 32'h8000_0000, 32'd4,          1'b0);
        send(2'b10, 32'h8000_0000, 32'd40,         1'b0);
        send(2'b11, 32'h0000_00F1, 32'd36,         1'b1);
        send(2'b11, 32'h8000_0000, 32'd32,         1'b0);
        send(2'b01, 32'h8000_0000, 32'd32,         1'b0);
        send(2'b00, 32'hFFFF_FFFF, 32'd33,         1'b1);
        send(2'b01, 32'h1234_5678, 32'h0000_0100,  1'b1);
        send(2'b00, 32'h0000_0001, 32'd32,         1'b0);
        send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FF21,  1'b1);

        // Starts during SHIFT must be dropped; the LSL-by-31 result still arrives.
        send(2'b00, 32'h0000_0003, 32'd31, 1'b0);
        poke(2'b01, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        poke(2'b10, 32'h8000_0000, 32'd40, 1'b1, 1'b0);
        @(negedge clk);
        poke(2'b11, 32'h1111_1111, 32'd5, 1'b0, 1'b0);
        send(2'b10, 32'hF000_000F, 32'd3, 1'b0);
        send(2'b11, 32'hA5A5_0001, 32'd0, 1'b1);

        // Asynchronous reset mid-SHIFT discards the in-flight operation.
        send(2'b00, $urandom, 32'd20, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_result", result, 32'd0);
        check("arst_carry", {31'd0, carry_out}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(2'b01, 32'h8000_0000, 32'd7, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = {$urandom_range(0, 32'hFF_FFFF), 8'($urandom_range(0, 40))};
                2: a = {$urandom_range(0, 32'hFF_FFFF), 8'd32};
                default: a = 32'($urandom_range(0, 8));
            endcase
            send(2'($urandom), $urandom, a, 1'($urandom));
        end

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        if (q.size() != 0) fail_now("drain_timeout");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
